// File: rtl/swap_reg_file_if.sv
`default_nettype none
// ============================================================================
// Module   : swap_reg_file_if
// Brief    : Write/read/swap-handshake bundle between swapper controller and
//            the swap register file.
// Revision : 1.0
// ============================================================================
interface swap_reg_file_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
);
  logic                  we;
  logic [ADDR_WIDTH-1:0] address_w;
  logic [DATA_WIDTH-1:0] data_w;
  logic [ADDR_WIDTH-1:0] address_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  swap_start;
  logic [ADDR_WIDTH-1:0] swap_addr_a;
  logic [ADDR_WIDTH-1:0] swap_addr_b;
  logic [ADDR_WIDTH:0]   swap_len;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output we, address_w, data_w, address_r,
    output swap_start, swap_addr_a, swap_addr_b, swap_len,
    input  data_r, busy, done, err
  );

  modport slave (
    input  we, address_w, data_w, address_r,
    input  swap_start, swap_addr_a, swap_addr_b, swap_len,
    output data_r, busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/swap_reg_file.sv
`default_nettype none
// ============================================================================
// Module   : swap_reg_file
// Brief    : Register file with external write port, combinational read port
//            and an internal engine that swaps two address ranges word-by-word.
// Revision : 1.0
// ============================================================================
module swap_reg_file #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  swap_reg_file_if.slave bus
);
  localparam int                  c_DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_LEN_MAX  = (ADDR_WIDTH+1)'(c_DEPTH);
  localparam logic [ADDR_WIDTH:0] c_LEN_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] c_LEN_ZERO = '0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR_A = 3'd2,
    S_WR_B = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_next;

  logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
  logic [ADDR_WIDTH-1:0] r_pa;
  logic [ADDR_WIDTH-1:0] r_pb;
  logic [ADDR_WIDTH:0]   r_cnt;
  logic [DATA_WIDTH-1:0] r_tmp_a;
  logic [DATA_WIDTH-1:0] r_tmp_b;
  logic                  r_err;

  logic                  w_load;
  logic                  w_advance;
  logic                  w_err_next;
  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_data;

  // Single write port: external writes own it in IDLE, the engine in WR_A/WR_B.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_advance    = 1'b0;
    w_err_next   = 1'b0;
    w_mem_we     = 1'b0;
    w_mem_addr   = bus.address_w;
    w_mem_data   = bus.data_w;

    case (r_state)
      S_IDLE: begin
        w_mem_we = bus.we;
        if (bus.swap_start) begin
          if (bus.swap_len > c_LEN_MAX) begin
            w_err_next = 1'b1;
          end else if (bus.swap_len == c_LEN_ZERO) begin
            w_state_next = S_FIN;
          end else begin
            w_load       = 1'b1;
            w_state_next = S_RD;
          end
        end
      end
      S_RD: begin
        w_state_next = S_WR_A;
      end
      S_WR_A: begin
        w_mem_we     = 1'b1;
        w_mem_addr   = r_pa;
        w_mem_data   = r_tmp_b;
        w_state_next = S_WR_B;
      end
      S_WR_B: begin
        w_mem_we     = 1'b1;
        w_mem_addr   = r_pb;
        w_mem_data   = r_tmp_a;
        w_advance    = 1'b1;
        w_state_next = (r_cnt == c_LEN_ONE) ? S_FIN : S_RD;
      end
      S_FIN: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pa    <= '0;
      r_pb    <= '0;
      r_cnt   <= '0;
      r_tmp_a <= '0;
      r_tmp_b <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_err   <= w_err_next;
      if (w_load) begin
        r_pa  <= bus.swap_addr_a;
        r_pb  <= bus.swap_addr_b;
        r_cnt <= bus.swap_len;
      end else if (w_advance) begin
        r_pa  <= r_pa + 1'b1;
        r_pb  <= r_pb + 1'b1;
        r_cnt <= r_cnt - 1'b1;
      end
      if (r_state == S_RD) begin
        r_tmp_a <= r_mem[r_pa];
        r_tmp_b <= r_mem[r_pb];
      end
    end
  end

  // Contents survive reset; a reset edge only blocks the write it coincides with.
  always_ff @(posedge clk) begin
    if (!reset && w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_data;
    end
  end

  assign bus.data_r = r_mem[bus.address_r];
  assign bus.busy   = (r_state != S_IDLE);
  assign bus.done   = (r_state == S_FIN);
  assign bus.err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_swap_reg_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_swap_reg_file
// Brief    : Directed self-checking bench for swap_reg_file.
// Revision : 1.0
// ============================================================================
module tb_swap_reg_file;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  logic [7:0] exp_mem [128];

  swap_reg_file_if #(.ADDR_WIDTH(7), .DATA_WIDTH(8)) bus ();

  swap_reg_file #(.ADDR_WIDTH(7), .DATA_WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic preload();
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      bus.we        = 1'b1;
      bus.address_w = 7'(i);
      bus.data_w    = 8'(i);
      exp_mem[i]    = 8'(i);
    end
    @(negedge clk);
    bus.we = 1'b0;
  endtask

  // Issue one start and observe every cycle until busy falls (or bound expires).
  task automatic run_swap(input logic [6:0] a, input logic [6:0] b, input logic [7:0] len,
                          input int bound, output int busy_cnt, output int done_cnt,
                          output int done_at, output int err_cnt, output bit timeout);
    @(negedge clk);
    bus.swap_start  = 1'b1;
    bus.swap_addr_a = a;
    bus.swap_addr_b = b;
    bus.swap_len    = len;
    @(negedge clk);
    bus.swap_start = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_at = -1; err_cnt = 0; timeout = 1'b1;
    for (int i = 0; i < bound; i++) begin
      if (bus.done) begin done_cnt++; done_at = i; end
      if (bus.err) err_cnt++;
      if (!bus.busy) begin timeout = 1'b0; break; end
      busy_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.busy, bus.done, bus.err} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_outputs: busy/done/err=%b want 000", {bus.busy, bus.done, bus.err});
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.busy, bus.done, bus.err} !== 3'b000) begin
      n_bad++;
      $display("FAIL post_reset_outputs: busy/done/err=%b want 000", {bus.busy, bus.done, bus.err});
    end
  endtask

  task automatic test_basic_swap();
    int bc, dc, da, ec; bit to;
    preload();
    run_swap(7'h10, 7'h40, 8'd4, 100, bc, dc, da, ec, to);
    for (int i = 0; i < 4; i++) begin
      exp_mem[16+i] = 8'(64+i);
      exp_mem[64+i] = 8'(16+i);
    end
    n_cmp++; if (to)      begin n_bad++; $display("FAIL basic_timeout: busy never fell"); end
    n_cmp++; if (bc != 13) begin n_bad++; $display("FAIL basic_busy_cycles: got %0d want 13", bc); end
    n_cmp++; if (dc != 1)  begin n_bad++; $display("FAIL basic_done_count: got %0d want 1", dc); end
    n_cmp++; if (da != 12) begin n_bad++; $display("FAIL basic_done_latency: got %0d want 12", da); end
    n_cmp++; if (ec != 0)  begin n_bad++; $display("FAIL basic_err: got %0d want 0", ec); end
    for (int i = 0; i < 128; i++) begin
      bus.address_r = 7'(i); #1;
      n_cmp++;
      if (bus.data_r !== exp_mem[i]) begin
        n_bad++; $display("FAIL basic_mem[%02h]: got %02h want %02h", i, bus.data_r, exp_mem[i]);
      end
    end
  endtask

  task automatic test_wrap();
    int bc, dc, da, ec; bit to;
    preload();
    run_swap(7'h7E, 7'h20, 8'd3, 100, bc, dc, da, ec, to);
    exp_mem[8'h7E] = 8'h20; exp_mem[8'h7F] = 8'h21; exp_mem[8'h00] = 8'h22;
    exp_mem[8'h20] = 8'h7E; exp_mem[8'h21] = 8'h7F; exp_mem[8'h22] = 8'h00;
    n_cmp++; if (to || da != 9) begin n_bad++; $display("FAIL wrap_done_latency: got %0d want 9", da); end
    for (int i = 0; i < 128; i++) begin
      bus.address_r = 7'(i); #1;
      n_cmp++;
      if (bus.data_r !== exp_mem[i]) begin
        n_bad++; $display("FAIL wrap_mem[%02h]: got %02h want %02h", i, bus.data_r, exp_mem[i]);
      end
    end
  endtask

  task automatic test_len_zero();
    int bc, dc, da, ec; bit to;
    run_swap(7'h05, 7'h06, 8'd0, 20, bc, dc, da, ec, to);
    n_cmp++; if (to || bc != 1) begin n_bad++; $display("FAIL len0_busy_cycles: got %0d want 1", bc); end
    n_cmp++; if (dc != 1 || da != 0) begin n_bad++; $display("FAIL len0_done: count %0d at %0d want 1 at 0", dc, da); end
    for (int i = 0; i < 128; i++) begin
      bus.address_r = 7'(i); #1;
      n_cmp++;
      if (bus.data_r !== exp_mem[i]) begin
        n_bad++; $display("FAIL len0_mem[%02h]: got %02h want %02h", i, bus.data_r, exp_mem[i]);
      end
    end
  endtask

  task automatic test_len_reject();
    int bc, dc, da, ec; bit to;
    run_swap(7'h05, 7'h06, 8'd129, 20, bc, dc, da, ec, to);
    n_cmp++; if (to || bc != 0) begin n_bad++; $display("FAIL reject_busy_cycles: got %0d want 0", bc); end
    n_cmp++; if (ec != 1) begin n_bad++; $display("FAIL reject_err_count: got %0d want 1", ec); end
    n_cmp++; if (dc != 0) begin n_bad++; $display("FAIL reject_done_count: got %0d want 0", dc); end
    @(negedge clk);
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL reject_err_width: err=%b want 0", bus.err); end
    for (int i = 0; i < 128; i++) begin
      bus.address_r = 7'(i); #1;
      n_cmp++;
      if (bus.data_r !== exp_mem[i]) begin
        n_bad++; $display("FAIL reject_mem[%02h]: got %02h want %02h", i, bus.data_r, exp_mem[i]);
      end
    end
  endtask

  task automatic test_len_full();
    int bc, dc, da, ec; bit to;
    run_swap(7'h00, 7'h00, 8'd128, 1000, bc, dc, da, ec, to);
    n_cmp++; if (to || bc != 385) begin n_bad++; $display("FAIL full_busy_cycles: got %0d want 385", bc); end
    n_cmp++; if (dc != 1 || da != 384) begin n_bad++; $display("FAIL full_done: count %0d at %0d want 1 at 384", dc, da); end
    for (int i = 0; i < 128; i++) begin
      bus.address_r = 7'(i); #1;
      n_cmp++;
      if (bus.data_r !== exp_mem[i]) begin
        n_bad++; $display("FAIL full_mem[%02h]: got %02h want %02h", i, bus.data_r, exp_mem[i]);
      end
    end
  endtask

  task automatic test_contention();
    int bc, dc, ec; bit to;
    preload();
    @(negedge clk);
    bus.swap_start = 1'b1; bus.swap_addr_a = 7'h10; bus.swap_addr_b = 7'h40; bus.swap_len = 8'd4;
    @(negedge clk);
    bus.swap_start = 1'b0;
    bc = 0; dc = 0; ec = 0; to = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (i == 2) begin
        bus.we = 1'b1; bus.address_w = 7'h11; bus.data_w = 8'hAA;
        bus.swap_start = 1'b1; bus.swap_addr_a = 7'h50;
      end else begin
        bus.we = 1'b0; bus.swap_start = 1'b0;
      end
      if (bus.done) dc++;
      if (bus.err) ec++;
      if (!bus.busy) begin to = 1'b0; break; end
      bc++;
      @(negedge clk);
    end
    bus.we = 1'b0; bus.swap_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_mem[16+i] = 8'(64+i);
      exp_mem[64+i] = 8'(16+i);
    end
    n_cmp++; if (to || bc != 13) begin n_bad++; $display("FAIL contend_busy_cycles: got %0d want 13", bc); end
    n_cmp++; if (dc != 1 || ec != 0) begin n_bad++; $display("FAIL contend_pulses: done %0d err %0d want 1 0", dc, ec); end
    repeat (20) @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL contend_restart: busy=%b want 0", bus.busy); end
    for (int i = 0; i < 128; i++) begin
      bus.address_r = 7'(i); #1;
      n_cmp++;
      if (bus.data_r !== exp_mem[i]) begin
        n_bad++; $display("FAIL contend_mem[%02h]: got %02h want %02h", i, bus.data_r, exp_mem[i]);
      end
    end
  endtask

  task automatic test_same_cycle();
    int bc, dc; bit to;
    preload();
    @(negedge clk);
    bus.we = 1'b1; bus.address_w = 7'h10; bus.data_w = 8'h99;
    bus.swap_start = 1'b1; bus.swap_addr_a = 7'h10; bus.swap_addr_b = 7'h40; bus.swap_len = 8'd1;
    @(negedge clk);
    bus.we = 1'b0; bus.swap_start = 1'b0;
    bc = 0; dc = 0; to = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (bus.done) dc++;
      if (!bus.busy) begin to = 1'b0; break; end
      bc++;
      @(negedge clk);
    end
    exp_mem[8'h40] = 8'h99;
    exp_mem[8'h10] = 8'h40;
    n_cmp++; if (to || bc != 4 || dc != 1) begin n_bad++; $display("FAIL same_timing: busy %0d done %0d want 4 1", bc, dc); end
    for (int i = 0; i < 128; i++) begin
      bus.address_r = 7'(i); #1;
      n_cmp++;
      if (bus.data_r !== exp_mem[i]) begin
        n_bad++; $display("FAIL same_mem[%02h]: got %02h want %02h", i, bus.data_r, exp_mem[i]);
      end
    end
  endtask

  task automatic test_reset_mid_swap();
    int bc, dc, da, ec; bit to;
    preload();
    @(negedge clk);
    bus.swap_start = 1'b1; bus.swap_addr_a = 7'h10; bus.swap_addr_b = 7'h40; bus.swap_len = 8'd4;
    @(negedge clk);
    bus.swap_start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      n_bad++; $display("FAIL midreset_outputs: busy/done=%b want 00", {bus.busy, bus.done});
    end
    exp_mem[8'h10] = 8'h40;
    exp_mem[8'h40] = 8'h10;
    for (int i = 0; i < 128; i++) begin
      bus.address_r = 7'(i); #1;
      n_cmp++;
      if (bus.data_r !== exp_mem[i]) begin
        n_bad++; $display("FAIL midreset_mem[%02h]: got %02h want %02h", i, bus.data_r, exp_mem[i]);
      end
    end
    run_swap(7'h20, 7'h30, 8'd2, 100, bc, dc, da, ec, to);
    exp_mem[8'h20] = 8'h30; exp_mem[8'h21] = 8'h31;
    exp_mem[8'h30] = 8'h20; exp_mem[8'h31] = 8'h21;
    n_cmp++; if (to || bc != 7 || dc != 1 || da != 6) begin
      n_bad++; $display("FAIL midreset_restart: busy %0d done %0d at %0d want 7 1 6", bc, dc, da);
    end
    for (int i = 0; i < 128; i++) begin
      bus.address_r = 7'(i); #1;
      n_cmp++;
      if (bus.data_r !== exp_mem[i]) begin
        n_bad++; $display("FAIL restart_mem[%02h]: got %02h want %02h", i, bus.data_r, exp_mem[i]);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.we = 1'b0; bus.address_w = '0; bus.data_w = '0; bus.address_r = '0;
    bus.swap_start = 1'b0; bus.swap_addr_a = '0; bus.swap_addr_b = '0; bus.swap_len = '0;
    test_reset();
    test_basic_swap();
    test_wrap();
    test_len_zero();
    test_len_reject();
    test_len_full();
    test_contention();
    test_same_cycle();
    test_reset_mid_swap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/swap_reg_file.md
Name: swap_reg_file

Overview:
- Parametrised successor to the single-write/single-read register file used by the memory swapper.
- Keeps the external write port and the combinational read port.
- Adds an internal swap engine that exchanges two address ranges word-by-word under a start/busy/done handshake.
- Sits between the swapper controller and the data path; the controller issues block swaps instead of sequencing reads and writes itself.

Parameters:
- ADDR_WIDTH, 7, address bits; DEPTH = 2**ADDR_WIDTH words.
- DATA_WIDTH, 8, bits per word.

Ports:
- clk  input  1  rising-edge clock, sole clock domain.
- reset  input  1  synchronous, active-high reset.
- we  input  1  external write enable.
- address_w  input  ADDR_WIDTH  external write address.
- data_w  input  DATA_WIDTH  external write data.
- address_r  input  ADDR_WIDTH  read address.
- data_r  output  DATA_WIDTH  combinational read data, mem[address_r].
- swap_start  input  1  request a swap; sampled only in IDLE.
- swap_addr_a  input  ADDR_WIDTH  base of range A.
- swap_addr_b  input  ADDR_WIDTH  base of range B.
- swap_len  input  ADDR_WIDTH+1  word count, 0..DEPTH.
- busy  output  1  engine active (any state except IDLE).
- done  output  1  one-cycle pulse when a swap completes.
- err  output  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset
  - Memory contents are not cleared.
  - FSM goes to IDLE; busy=0, done=0, err=0; pointers, counter and temps are cleared.
  - Reset mid-swap abandons the operation. Words already written stay swapped; the remaining words are untouched.
- data_r
  - Always mem[address_r], combinational.
  - During a swap it reflects partially swapped contents.
- FSM states: IDLE, RD, WR_A, WR_B, FIN.
- IDLE
  - swap_start=1 and swap_len>DEPTH: err=1 for the next cycle; stay in IDLE.
  - swap_start=1 and swap_len=0: go to FIN.
  - swap_start=1 otherwise: latch pa=swap_addr_a, pb=swap_addr_b, cnt=swap_len; go to RD.
- RD: tmp_a<=mem[pa], tmp_b<=mem[pb]; go to WR_A.
- WR_A: mem[pa]<=tmp_b; go to WR_B.
- WR_B
  - mem[pb]<=tmp_a; pa<=pa+1, pb<=pb+1, both modulo DEPTH; cnt<=cnt-1.
  - If cnt==1, go to FIN; else go to RD.
- FIN: done=1; go to IDLE.
- Latency
  - With start accepted at edge 0, FIN is occupied between edges 3*len and 3*len+1.
  - busy is high from edge 0 until edge 3*len+1.
  - len=0 gives done one cycle after start.
- Pointer wrap: pointers wrap modulo DEPTH; range A may span address DEPTH-1 -> 0.
- Overlapping ranges: the result is defined as the sequential per-word swap in ascending index order exactly as the FSM executes it. No overlap detection. pa==pb leaves contents unchanged but still takes 3*len cycles.
- External write
  - When busy=0 and we=1, mem[address_w]<=data_w.
  - When busy=1, external writes are ignored (dropped, not queued).
  - we and an accepted swap_start in the same IDLE cycle: the write commits at that edge, and the swap's first RD sees the new value.
- Other start conditions: swap_start while busy is ignored (no err). done and err are never high together.
- Only one memory write occurs per cycle.

Test Plan:
- Preload mem[i]=i for i=0..127; swap a=0x10, b=0x40, len=4.
  - Required: mem[0x10..0x13]=0x40..0x43 and mem[0x40..0x43]=0x10..0x13.
  - busy high for 13 cycles; done pulses exactly once, 12 cycles after start.
- Wrap: preload as above; a=0x7E, b=0x20, len=3.
  - Required: mem[0x7E]=0x20, mem[0x7F]=0x21, mem[0x00]=0x22, and mem[0x20..0x22]=0x7E,0x7F,0x00.
- Boundaries and rejection:
  - len=0 -> done on the next cycle, memory unchanged, busy one cycle.
  - len=129 -> err one cycle, busy stays 0, memory unchanged.
  - len=128, a=0, b=0 -> memory unchanged, done after 384 cycles.
- Contention: during busy, drive we=1, address_w=0x11, data_w=0xAA, and pulse swap_start with a=0x50.
  - Required: write dropped, second start ignored, final contents match the first scenario.
- Same-cycle: we=1, address_w=0x10, data_w=0x99 together with swap_start, a=0x10, b=0x40, len=1.
  - Required: mem[0x40]=0x99 and mem[0x10]=0x40.
- Reset mid-swap: assert reset for 1 cycle at edge 5 of the first scenario.
  - Required: busy=0, done=0 next cycle; only word 0 is swapped (mem[0x10]=0x40, mem[0x40]=0x10), and mem[0x11], mem[0x41] keep their original values.
  - A new swap starts normally afterward.
